alu_uart_if: RTL

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_uart_if.sv | 100 ++++++++++
 1 files changed

// File: rtl/alu_uart_if.sv
// alu_uart_if: collects operand A, operand B and an opcode from UART bytes, drives the ALU and transmits the result byte.
// Define ALU_UART_IF_ZERO_FLAG_EN to also transmit the ALU zero flag as a second byte (8'h01 or 8'h00).
module alu_uart_if #(
  parameter int bits = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rx_data,
  input  logic            rx_done,
  input  logic [bits-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            tx_busy,
  output logic [bits-1:0] A,
  output logic [bits-1:0] B,
  output logic [3:0]      select,
  output logic [7:0]      tx_data,
  output logic            tx_start
);
  typedef enum logic [2:0] {
    GET_A, GET_B, GET_OP, CAPTURE, SEND_RES, WAIT_RES
`ifdef ALU_UART_IF_ZERO_FLAG_EN
    , SEND_ZF, WAIT_ZF
`endif
  } state_t;
  state_t          state_q;
  logic [bits-1:0] a_q, b_q;
  logic [3:0]      sel_q;
  logic [7:0]      res_q, tx_data_q, tx_byte;
  logic            seen_q, send;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
  localparam state_t AFTER_RES = SEND_ZF;
  logic zf_q;
  assign send    = !tx_busy && (state_q == SEND_RES || state_q == SEND_ZF);
  assign tx_byte = state_q == SEND_ZF ? {7'b0, zf_q} : res_q;
`else
  localparam state_t AFTER_RES = GET_A;
  logic unused_zf;
  assign unused_zf = alu_zero;
  assign send      = !tx_busy && state_q == SEND_RES;
  assign tx_byte   = res_q;
`endif
  // The launch byte is presented in the same cycle as tx_start so the result leaves two cycles after the opcode.
  assign tx_start = send;
  assign tx_data  = send ? tx_byte : tx_data_q;
  assign A        = a_q;
  assign B        = b_q;
  assign select   = sel_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= GET_A;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      res_q     <= '0;
      tx_data_q <= '0;
      seen_q    <= 1'b0;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
      zf_q      <= 1'b0;
`endif
    end else begin
      if (send) tx_data_q <= tx_byte;
      case (state_q)
        GET_A: if (rx_done) begin
          a_q     <= bits'($signed(rx_data));
          state_q <= GET_B;
        end
        GET_B: if (rx_done) begin
          b_q     <= bits'($signed(rx_data));
          state_q <= GET_OP;
        end
        GET_OP: if (rx_done) begin
          sel_q   <= rx_data[3:0];
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          res_q   <= alu_result[7:0];
`ifdef ALU_UART_IF_ZERO_FLAG_EN
          zf_q    <= alu_zero;
`endif
          state_q <= SEND_RES;
        end
        SEND_RES: if (!tx_busy) begin
          seen_q  <= 1'b0;
          state_q <= WAIT_RES;
        end
        // Wait for the transmitter to acknowledge (busy rises) and then finish (busy falls).
        WAIT_RES: if (tx_busy) seen_q <= 1'b1;
          else if (seen_q) state_q <= AFTER_RES;
`ifdef ALU_UART_IF_ZERO_FLAG_EN
        SEND_ZF: if (!tx_busy) begin
          seen_q  <= 1'b0;
          state_q <= WAIT_ZF;
        end
        WAIT_ZF: if (tx_busy) seen_q <= 1'b1;
          else if (seen_q) state_q <= GET_A;
`endif
        default: state_q <= GET_A;
      endcase
    end
endmodule
